debounce_multi: RTL
===================

Name: debounce_multi

Overview:
Parametrised multi-channel successor to the single-button debouncer. It debounces NCH asynchronous button inputs against a shared pulse tick tp_i. Each channel has its own synchroniser, FSM and counter, and rejects glitches by aborting a count when the input reverts. Outputs per channel: a debounced level plus registered press and release strobes, feeding the TapTempo tap-period measurement and any future UI buttons.

Parameters:
NCH, 4, number of independent button channels (>=1)
CNT_MAX, 4096, number of tp_i ticks an input must stay stable before a level change is accepted (>=1; 4096 x 5120 ns ≈ 21 ms)
CNT_W, $clog2(CNT_MAX+1), counter width (derived, not overridden)
SYNC_STAGES, 2, flops in each input synchroniser (>=2)
HOLD_TICKS, 65536, tp_i ticks for long-press/repeat (used only with DEBOUNCE_HOLD_EN)

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
tp_i  input  1  one-clk_i-cycle timebase pulse, shared by all channels
btn_i  input  NCH  raw asynchronous button inputs, active high
btn_o  output  NCH  debounced levels
rise_o  output  NCH  one-cycle pulse per accepted press
fall_o  output  NCH  one-cycle pulse per accepted release
hold_o  output  NCH  one-cycle long-press/repeat pulse (0 when the feature is out)

Behaviour:
- Reset (rst_ni=0, asynchronous): all synchroniser flops 0; all FSMs S_IDLE_LOW; all counters 0; btn_o, rise_o, fall_o, hold_o = 0. Deasserting reset mid-count drops that count; there is no partial state.
- Synchroniser: btn_i[n] passes through SYNC_STAGES flops to give s[n]. A change on btn_i is visible to the FSM SYNC_STAGES cycles later.
- Per-channel FSM, 2-bit encoded: S_IDLE_LOW, S_CNT_HIGH, S_IDLE_HIGH, S_CNT_LOW.
  - S_IDLE_LOW, s=1: go to S_CNT_HIGH, counter=0.
  - S_CNT_HIGH, s=0: abort to S_IDLE_LOW, counter=0. Abort has priority over tp_i in the same cycle.
  - S_CNT_HIGH, s=1 and tp_i=1: counter+1. If counter==CNT_MAX-1, go to S_IDLE_HIGH instead and clear counter.
  - S_IDLE_HIGH and S_CNT_LOW: mirror of the two rules above, with s inverted.
- Counting: the counter advances only on tp_i cycles and saturates safely; it can never exceed CNT_MAX-1. An acceptance therefore needs exactly CNT_MAX tp_i pulses of continuous stable input after count entry.
- Output level: btn_o[n]=1 iff the FSM is in S_IDLE_HIGH or S_CNT_LOW. btn_o is registered and changes the cycle after the accepting tp_i cycle. Glitches shorter than the count window never reach btn_o.
- Strobes:
  - rise_o[n] is 1 for exactly one cycle, in the same cycle btn_o[n] goes 0->1.
  - fall_o[n] behaves likewise for 1->0.
  - rise_o and fall_o are never both 1 on a channel.
- Channels are fully independent; simultaneous events on several channels are each handled in the same cycle.
- tp_i held high for several cycles (protocol violation) counts once per cycle; no protection is required.

Optional Feature:
Macro DEBOUNCE_HOLD_EN.
- Defined: each channel adds a hold counter that counts tp_i only while the FSM is in S_IDLE_HIGH and is cleared on any other state.
  - Reaching HOLD_TICKS pulses hold_o[n] for one cycle and reloads the counter to 0, so the pulse repeats every HOLD_TICKS ticks while the button stays held.
  - The first hold pulse comes HOLD_TICKS ticks after rise_o.
- Undefined: no hold logic is synthesised and hold_o is tied to 0.

Test Plan:
(All scenarios use NCH=2, CNT_MAX=3, SYNC_STAGES=2, tp_i pulsed every 4 cycles.)
- Reset: hold rst_ni=0 while btn_i=2'b11 -> all outputs 0. Release reset with btn_i=2'b11 -> btn_o[0] rises after the 3rd tp_i following count entry; rise_o=1 for one cycle.
- Clean press then release on ch0 -> rise_o[0] one cycle, btn_o[0]=1, 3 ticks later fall_o[0] one cycle, btn_o[0]=0; ch1 stays 0 throughout.
- Glitch: btn_i[0] high for 2 tp_i ticks then low -> btn_o[0] stays 0, no strobe, FSM back in S_IDLE_LOW with counter 0.
- Revert coincident with tp_i in the cycle that would be the 3rd tick -> abort wins; btn_o unchanged.
- Both channels pressed in the same cycle -> rise_o=2'b11 in one cycle. Assert rst_ni=0 mid-count on ch1 -> immediate clear of all outputs and state.
- With DEBOUNCE_HOLD_EN and HOLD_TICKS=5, hold ch0 for 12 ticks after rise_o -> hold_o[0] pulses at tick 5 and tick 10 only; without the macro, hold_o=0 throughout.

Source files
------------

// File: rtl/debounce_multi.sv
// debounce_multi: NCH-channel button debouncer against a shared tp_i tick, with press/release strobes.
// Define DEBOUNCE_HOLD_EN to add the per-channel long-press/repeat pulse on hold_o.
module debounce_multi #(
  parameter int NCH         = 4,
  parameter int CNT_MAX     = 4096,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_TICKS  = 65536
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           tp_i,
  input  logic [NCH-1:0] btn_i,
  output logic [NCH-1:0] btn_o,
  output logic [NCH-1:0] rise_o,
  output logic [NCH-1:0] fall_o,
  output logic [NCH-1:0] hold_o
);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  // bit 1 is the accepted level, bit 0 marks a count in progress
  typedef enum logic [1:0] {
    S_IDLE_LOW  = 2'd0,
    S_CNT_HIGH  = 2'd1,
    S_IDLE_HIGH = 2'd2,
    S_CNT_LOW   = 2'd3
  } state_e;
  logic [SYNC_STAGES-1:0][NCH-1:0] sync_q;
  logic [NCH-1:0] s;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
  end
  assign s = sync_q[SYNC_STAGES-1];
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic btn_q, rise_q, fall_q, btn_d, hi, done;
    assign hi   = state_q[1];
    assign done = cnt_q >= CNT_W'(CNT_MAX - 1);
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!state_q[0]) begin
        if (s[g] != hi) begin
          state_d = hi ? S_CNT_LOW : S_CNT_HIGH;
          cnt_d   = '0;
        end
      end else if (s[g] == hi) begin
        state_d = hi ? S_IDLE_HIGH : S_IDLE_LOW;
        cnt_d   = '0;
      end else if (tp_i) begin
        state_d = done ? (hi ? S_IDLE_LOW : S_IDLE_HIGH) : state_q;
        cnt_d   = done ? '0 : cnt_q + 1'b1;
      end
    end
    assign btn_d = state_d[1];
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= S_IDLE_LOW;
        cnt_q   <= '0;
        btn_q   <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        btn_q   <= btn_d;
        rise_q  <= btn_d & ~btn_q;
        fall_q  <= ~btn_d & btn_q;
      end
    end
    assign btn_o[g]  = btn_q;
    assign rise_o[g] = rise_q;
    assign fall_o[g] = fall_q;
`ifdef DEBOUNCE_HOLD_EN
    localparam int HW = $clog2(HOLD_TICKS + 1);
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic hold_q, hold_hit;
    always_comb begin
      hold_hit   = (state_q == S_IDLE_HIGH) && tp_i && (hold_cnt_q >= HW'(HOLD_TICKS - 1));
      hold_cnt_d = (state_q != S_IDLE_HIGH || hold_hit) ? '0 : tp_i ? hold_cnt_q + 1'b1 : hold_cnt_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        hold_cnt_q <= '0;
        hold_q     <= 1'b0;
      end else begin
        hold_cnt_q <= hold_cnt_d;
        hold_q     <= hold_hit;
      end
    end
    assign hold_o[g] = hold_q;
`else
    // no hold logic; the constant compare keeps HOLD_TICKS referenced in this build
    assign hold_o[g] = (HOLD_TICKS < 0);
`endif
  end
endmodule
